// File: rtl/qr_pkg.sv
// Shared types and constants for the QR pattern-detection pixel path:
// arbiter state encoding, frame geometry and the read-tag record that
// travels alongside each frame-buffer read.
package qr_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int PIXEL_ADDR_WIDTH = 20;
    localparam int FRAME_WIDTH      = 480;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } rd_tag_t;

    // Round-robin successor of a requester index, wrapping the last one to 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int num_req);
        logic [1:0] nxt;
        if (int'(idx) >= num_req - 1) begin
            nxt = 2'd0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pixel_read_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit at or
// after ptr (with wrap) and returns it one-hot and as an index.
module rr_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx,
    output logic               grant_any
);

    logic [2:0] cand_s;

    // Scan requesters starting at ptr; the first one found wins.
    always_comb begin
        grant     = {NUM_REQ{1'b0}};
        grant_idx = 2'd0;
        grant_any = 1'b0;
        cand_s    = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, ptr} + 3'(k);
            if (cand_s >= 3'(NUM_REQ)) begin
                cand_s = cand_s - 3'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_any && req[cand_s[1:0]]) begin
                grant_any             = 1'b1;
                grant[cand_s[1:0]]    = 1'b1;
                grant_idx             = cand_s[1:0];
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/pixel_read_arbiter.sv
// Frame-buffer read-port arbiter: round-robin grant among NUM_REQ pixel
// readers with optional burst lock, registered BRAM issue, and a tag
// pipeline that steers each returning pixel to the requester that asked.
// Optional build macro PIXEL_ARB_STATS_EN adds per-requester saturating
// grant and stall counters.
module pixel_read_arbiter
    import qr_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = PIXEL_ADDR_WIDTH,
    parameter int DATA_WIDTH   = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ADDR_WIDTH-1:0]         bram_addr_out,
    output logic                          bram_en_out,
    input  logic [DATA_WIDTH-1:0]         bram_data_in,
    output logic                          busy
`ifdef PIXEL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_count,
    output logic [NUM_REQ*16-1:0]         stall_count
`endif
);

    arb_state_t              state_r;
    logic [1:0]              owner_r;
    logic [1:0]              rr_ptr_r;
    logic [1:0]              issue_id_r;
    rd_tag_t                 tag_r [READ_LATENCY];

    logic [NUM_REQ-1:0]      pick_grant_s;
    logic [1:0]              pick_idx_s;
    logic                    pick_any_s;
    logic [1:0]              win_idx_s;
    logic                    xfer_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic                    tag_busy_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (pick_grant_s),
        .grant_idx (pick_idx_s),
        .grant_any (pick_any_s)
    );

    // Grant: round-robin pick in ARB, owner-only while a burst lock is held.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        win_idx_s = 2'd0;
        if (state_r == LOCKED) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = req_valid[i] && (owner_r == 2'(i));
            end
            win_idx_s = owner_r;
        end else begin
            req_ready = pick_any_s ? pick_grant_s : {NUM_REQ{1'b0}};
            win_idx_s = pick_idx_s;
        end
        xfer_s = |req_ready;
    end

    // Select the winning requester's address from the packed bus.
    always_comb begin
        win_addr_s = {ADDR_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx_s == 2'(i)) begin
                win_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // Arbiter FSM: round-robin pointer update and lock ownership tracking.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r  <= ARB;
            rr_ptr_r <= 2'd0;
            owner_r  <= 2'd0;
        end else begin
            case (state_r)
                ARB: begin
                    if (xfer_s) begin
                        rr_ptr_r <= rr_next(win_idx_s, NUM_REQ);
                        if (req_lock[win_idx_s]) begin
                            owner_r <= win_idx_s;
                            state_r <= LOCKED;
                        end else begin
                            state_r <= ARB;
                        end
                    end else begin
                        state_r <= ARB;
                    end
                end
                LOCKED: begin
                    // The releasing edge may still carry a transfer; the
                    // pointer stays frozen for the whole burst.
                    if (!req_lock[owner_r]) begin
                        state_r <= ARB;
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

    // Issue stage: register the BRAM address/enable and remember who asked.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bram_addr_out <= {ADDR_WIDTH{1'b0}};
            bram_en_out   <= 1'b0;
            issue_id_r    <= 2'd0;
        end else if (xfer_s) begin
            bram_addr_out <= win_addr_s;
            bram_en_out   <= 1'b1;
            issue_id_r    <= win_idx_s;
        end else begin
            bram_en_out   <= 1'b0;
        end
    end

    // Tag pipeline: follows the BRAM latency so the last stage lines up
    // with bram_data_in for the read issued READ_LATENCY cycles earlier.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_r[i].valid <= 1'b0;
                tag_r[i].id    <= 2'd0;
            end
        end else begin
            tag_r[0].valid <= bram_en_out;
            tag_r[0].id    <= issue_id_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Response steering and activity flag.
    always_comb begin
        resp_valid = {NUM_REQ{1'b0}};
        if (tag_r[READ_LATENCY-1].valid) begin
            resp_valid[tag_r[READ_LATENCY-1].id] = 1'b1;
        end else begin
            resp_valid = {NUM_REQ{1'b0}};
        end
        resp_data  = bram_data_in;
        tag_busy_s = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            tag_busy_s = tag_busy_s | tag_r[i].valid;
        end
        busy = (state_r == LOCKED) | bram_en_out | tag_busy_s;
    end

`ifdef PIXEL_ARB_STATS_EN
    // Per-requester saturating transfer and stall counters.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            grant_count <= {(NUM_REQ*16){1'b0}};
            stall_count <= {(NUM_REQ*16){1'b0}};
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (grant_count[i*16 +: 16] != 16'hFFFF)) begin
                    grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
                end else begin
                    grant_count[i*16 +: 16] <= grant_count[i*16 +: 16];
                end
                if (req_valid[i] && !req_ready[i] && (stall_count[i*16 +: 16] != 16'hFFFF)) begin
                    stall_count[i*16 +: 16] <= stall_count[i*16 +: 16] + 16'd1;
                end else begin
                    stall_count[i*16 +: 16] <= stall_count[i*16 +: 16];
                end
            end
        end
    end
`endif

endmodule
